// File: rtl/sv32_ptw_pkg.sv
// Shared types and constants for the Sv32 page-table walker and its PTE checker.
package sv32_ptw_pkg;

  localparam int unsigned PA_WD       = 34;
  localparam int unsigned PTE_WD      = 32;
  localparam int unsigned PAGE_OFFSET = 12;

  typedef struct packed {
    logic [11:0] ppn1;
    logic [9:0]  ppn0;
    logic [1:0]  rsw;
    logic        d;
    logic        a;
    logic        g;
    logic        u;
    logic        x;
    logic        w;
    logic        r;
    logic        v;
  } sv32_pte_t;

  typedef enum logic [2:0] {
    IDLE,
    L1_REQ,
    L1_WAIT,
    L0_REQ,
    L0_WAIT,
    RESP
  } ptw_state_e;

  typedef struct packed {
    sv32_pte_t pte;
    logic      level;
    logic      page_fault;
    logic      access_err;
  } ptw_rsp_t;

endpackage

// File: rtl/sv32_ptw_pte_check.sv
// Structural PTE decode shared by both walk levels: leaf detection, malformed /
// misaligned / dangling-pointer faults, and bus-error reporting.
module sv32_pte_check
  import sv32_ptw_pkg::*;
(
  input  sv32_pte_t pte,
  input  logic      level,
  input  logic      err,
  output logic      is_leaf,
  output logic      page_fault,
  output logic      access_err
);

  // Permission and A/D bits are the TLB's business, not the walker's.
  logic unused_fields;
  assign unused_fields = ^{pte.ppn1, pte.rsw, pte.d, pte.a, pte.g, pte.u};

  // Priority: bus error, invalid/reserved encoding, misaligned superpage, pointer at level 0.
  always_comb begin
    is_leaf    = pte.r | pte.x;
    page_fault = 1'b0;
    access_err = 1'b0;
    if (err) begin
      access_err = 1'b1;
    end else if (!pte.v || (!pte.r && pte.w)) begin
      page_fault = 1'b1;
    end else if (is_leaf) begin
      page_fault = level && (pte.ppn0 != '0);
    end else begin
      page_fault = !level;
    end
  end

endmodule

// File: rtl/sv32_ptw.sv
// Sv32 hardware page-table walker: two-level walk with a single outstanding
// PTE read, returning the leaf PTE, its level, or a structural/bus fault.
module sv32_ptw
  import sv32_ptw_pkg::*;
#(
  parameter int unsigned PA_WD       = sv32_ptw_pkg::PA_WD,
  parameter int unsigned PTE_WD      = sv32_ptw_pkg::PTE_WD,
  parameter int unsigned PAGE_OFFSET = sv32_ptw_pkg::PAGE_OFFSET
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic [19:0]       req_vpn_i,
  input  logic [21:0]       satp_ppn_i,
  output logic              mem_req_valid_o,
  input  logic              mem_req_ready_i,
  output logic [PA_WD-1:0]  mem_req_addr_o,
  input  logic              mem_rsp_valid_i,
  input  logic [PTE_WD-1:0] mem_rsp_data_i,
  input  logic              mem_rsp_err_i,
  output logic              rsp_valid_o,
  input  logic              rsp_ready_i,
  output logic [PTE_WD-1:0] rsp_pte_o,
  output logic              rsp_level_o,
  output logic              rsp_page_fault_o,
  output logic              rsp_access_err_o
);

  // PTEs are 4 bytes, so the table index sits above the low byte-offset bits.
  localparam int unsigned IDX_LSB = PAGE_OFFSET - 10;

  ptw_state_e state, state_nxt;
  logic [PA_WD-1:0] addr_q;
  logic [9:0]       vpn0_q;
  ptw_rsp_t         rsp_q;
  sv32_pte_t        pte_in;
  logic             in_l1;
  logic             chk_leaf, chk_pf, chk_ae;

  assign pte_in = sv32_pte_t'(mem_rsp_data_i);
  assign in_l1  = (state == L1_WAIT);

  sv32_pte_check u_pte_check (
    .pte        (pte_in),
    .level      (in_l1),
    .err        (mem_rsp_err_i),
    .is_leaf    (chk_leaf),
    .page_fault (chk_pf),
    .access_err (chk_ae)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state and handshake decode.
  always_comb begin
    state_nxt       = state;
    req_ready_o     = 1'b0;
    mem_req_valid_o = 1'b0;
    rsp_valid_o     = 1'b0;
    unique case (state)
      IDLE: begin
        req_ready_o = 1'b1;
        if (req_valid_i) state_nxt = L1_REQ;
      end
      L1_REQ: begin
        mem_req_valid_o = 1'b1;
        if (mem_req_ready_i) state_nxt = L1_WAIT;
      end
      L1_WAIT: begin
        if (mem_rsp_valid_i) state_nxt = (chk_leaf || chk_pf || chk_ae) ? RESP : L0_REQ;
      end
      L0_REQ: begin
        mem_req_valid_o = 1'b1;
        if (mem_req_ready_i) state_nxt = L0_WAIT;
      end
      L0_WAIT: begin
        if (mem_rsp_valid_i) state_nxt = RESP;
      end
      RESP: begin
        rsp_valid_o = 1'b1;
        if (rsp_ready_i) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Request latching, PTE address formation and result capture.
  // The address register is loaded one state early so it is already stable
  // when the REQ state raises mem_req_valid_o.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q <= '0;
      vpn0_q <= '0;
      rsp_q  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid_i) begin
            addr_q <= {satp_ppn_i, req_vpn_i[19:10], {IDX_LSB{1'b0}}};
            vpn0_q <= req_vpn_i[9:0];
          end
        end
        L1_WAIT, L0_WAIT: begin
          if (mem_rsp_valid_i) begin
            rsp_q.pte        <= pte_in;
            rsp_q.level      <= in_l1;
            rsp_q.page_fault <= chk_pf;
            rsp_q.access_err <= chk_ae;
            if (in_l1) addr_q <= {pte_in.ppn1, pte_in.ppn0, vpn0_q, {IDX_LSB{1'b0}}};
          end
        end
        default: ;
      endcase
    end
  end

  assign mem_req_addr_o   = addr_q;
  assign rsp_pte_o        = rsp_q.pte;
  assign rsp_level_o      = rsp_q.level;
  assign rsp_page_fault_o = rsp_q.page_fault;
  assign rsp_access_err_o = rsp_q.access_err;

endmodule

// File: tb/tb_sv32_ptw.sv
// Scoreboard bench for sv32_ptw: a sparse memory image, a walk model computed
// from the Sv32 rules, a memory responder, and a monitor popping expectations.
module tb_sv32_ptw;

  localparam int unsigned PA_WD  = 34;
  localparam int unsigned PTE_WD = 32;

  logic              clk = 1'b0;
  logic              rst_n = 1'b1;
  logic              req_valid_i = 1'b0;
  logic              req_ready_o;
  logic [19:0]       req_vpn_i = '0;
  logic [21:0]       satp_ppn_i = '0;
  logic              mem_req_valid_o;
  logic              mem_req_ready_i = 1'b1;
  logic [PA_WD-1:0]  mem_req_addr_o;
  logic              mem_rsp_valid_i = 1'b0;
  logic [PTE_WD-1:0] mem_rsp_data_i = '0;
  logic              mem_rsp_err_i = 1'b0;
  logic              rsp_valid_o;
  logic              rsp_ready_i = 1'b1;
  logic [PTE_WD-1:0] rsp_pte_o;
  logic              rsp_level_o;
  logic              rsp_page_fault_o;
  logic              rsp_access_err_o;

  always #5 clk = ~clk;

  sv32_ptw #(.PA_WD(PA_WD), .PTE_WD(PTE_WD), .PAGE_OFFSET(12)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .req_valid_i      (req_valid_i),
    .req_ready_o      (req_ready_o),
    .req_vpn_i        (req_vpn_i),
    .satp_ppn_i       (satp_ppn_i),
    .mem_req_valid_o  (mem_req_valid_o),
    .mem_req_ready_i  (mem_req_ready_i),
    .mem_req_addr_o   (mem_req_addr_o),
    .mem_rsp_valid_i  (mem_rsp_valid_i),
    .mem_rsp_data_i   (mem_rsp_data_i),
    .mem_rsp_err_i    (mem_rsp_err_i),
    .rsp_valid_o      (rsp_valid_o),
    .rsp_ready_i      (rsp_ready_i),
    .rsp_pte_o        (rsp_pte_o),
    .rsp_level_o      (rsp_level_o),
    .rsp_page_fault_o (rsp_page_fault_o),
    .rsp_access_err_o (rsp_access_err_o)
  );

  typedef struct packed {
    logic [31:0] pte;
    logic        level;
    logic        pf;
    logic        ae;
  } exp_t;

  exp_t        exp_q[$];
  logic [33:0] addr_q[$];
  logic [31:0] pmem [logic [33:0]];
  bit          perr [logic [33:0]];

  int tests = 0;
  int fails = 0;
  int rsp_done = 0;
  int mem_acc = 0;
  bit rand_mode = 1'b0;
  bit hold_rsp = 1'b0;
  int mem_stall_cfg = 0;
  int rsp_stall_cfg = 0;
  int spur_cnt = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    tests++;
    fails++;
    $display("FAIL %s: wait bound expired, required the event", name);
  endtask

  function automatic logic [71:0] outs();
    return {req_ready_o, mem_req_valid_o, rsp_valid_o, mem_req_addr_o,
            rsp_pte_o, rsp_level_o, rsp_page_fault_o, rsp_access_err_o};
  endfunction

  function automatic logic [31:0] rd(input logic [33:0] a);
    return pmem.exists(a) ? pmem[a] : 32'h0;
  endfunction

  function automatic bit rd_err(input logic [33:0] a);
    return perr.exists(a) ? perr[a] : 1'b0;
  endfunction

  function automatic bit malformed(input logic [31:0] p);
    return (p[0] == 1'b0) || (p[1] == 1'b0 && p[2] == 1'b1);
  endfunction

  function automatic bit leaf(input logic [31:0] p);
    return p[1] || p[3];
  endfunction

  // Reference walk: PTE address = table base (ppn * 4 KiB) + index * 4 bytes.
  function automatic void model(input logic [21:0] satp, input logic [19:0] vpn,
                                output exp_t e, output logic [33:0] a1,
                                output logic [33:0] a0, output int n);
    logic [31:0] p;
    a1 = 34'(satp) * 34'd4096 + 34'(vpn[19:10]) * 34'd4;
    a0 = '0;
    n  = 1;
    p  = rd(a1);
    e  = '{pte: p, level: 1'b1, pf: 1'b0, ae: 1'b0};
    if (rd_err(a1)) begin e.ae = 1'b1; return; end
    if (malformed(p)) begin e.pf = 1'b1; return; end
    if (leaf(p)) begin e.pf = (p[19:10] != 10'd0); return; end
    a0 = 34'(p[31:10]) * 34'd4096 + 34'(vpn[9:0]) * 34'd4;
    n  = 2;
    p  = rd(a0);
    e  = '{pte: p, level: 1'b0, pf: 1'b0, ae: 1'b0};
    if (rd_err(a0)) e.ae = 1'b1;
    else if (malformed(p) || !leaf(p)) e.pf = 1'b1;
  endfunction

  function automatic logic [31:0] gen_pte();
    logic [21:0] ppn;
    logic [7:0]  hi;
    logic [7:0]  rwx;
    int          k;
    ppn = 22'($urandom);
    hi  = 8'($urandom) & 8'hF0;
    k   = $urandom_range(0, 4);
    rwx = (k == 0) ? 8'h02 : (k == 1) ? 8'h08 : (k == 2) ? 8'h0A : (k == 3) ? 8'h06 : 8'h0E;
    case ($urandom_range(0, 5))
      0:       return {ppn, 2'b00, hi | 8'h01};
      1:       return {ppn, 2'b00, hi | rwx | 8'h01};
      2:       return {ppn[21:10], 10'd0, 2'b00, hi | rwx | 8'h01};
      3:       return $urandom & 32'hFFFF_FFFE;
      4:       return {ppn, 2'b00, hi | (($urandom_range(0, 1) == 1) ? 8'h0D : 8'h05)};
      default: return $urandom;
    endcase
  endfunction

  // Memory side: checks each accepted address, answers after 1+ cycles.
  initial begin : responder
    logic [33:0] a;
    bit pv;
    int stall;
    int seen;
    int d;
    pv = 1'b0; stall = 0; seen = 0;
    forever begin
      @(negedge clk);
      if (rst_n && mem_req_valid_o && mem_req_ready_i) begin
        a = mem_req_addr_o;
        mem_acc++;
        if (addr_q.size() == 0) begin
          tests++; fails++;
          $display("FAIL mem_req_extra: got request to 0x%0h, required none", a);
        end else begin
          chk("mem_req_addr", 128'(a), 128'(addr_q.pop_front()));
        end
        @(posedge clk); #1;
        while (hold_rsp) begin @(posedge clk); #1; end
        d = rand_mode ? $urandom_range(0, 2) : 0;
        repeat (d) begin @(posedge clk); #1; end
        mem_rsp_valid_i = 1'b1;
        mem_rsp_data_i  = rd(a);
        mem_rsp_err_i   = rd_err(a);
        @(posedge clk); #1;
        mem_rsp_valid_i = 1'b0;
        mem_rsp_err_i   = 1'b0;
        mem_rsp_data_i  = $urandom;
      end else begin
        @(posedge clk); #1;
        if (spur_cnt != seen) begin
          seen = spur_cnt;
          mem_rsp_valid_i = 1'b1;
          mem_rsp_data_i  = 32'h0000_0C0F;
        end else begin
          mem_rsp_valid_i = 1'b0;
        end
      end
      if (mem_req_valid_o && !pv) stall = mem_stall_cfg;
      pv = mem_req_valid_o;
      if (mem_req_valid_o && stall > 0) begin
        mem_req_ready_i = 1'b0;
        stall--;
      end else begin
        mem_req_ready_i = rand_mode ? ($urandom_range(0, 2) != 0) : 1'b1;
      end
    end
  end

  // Result side backpressure.
  initial begin : rsp_drv
    bit pv;
    int stall;
    pv = 1'b0; stall = 0;
    forever begin
      @(posedge clk); #1;
      if (rsp_valid_o && !pv) stall = rsp_stall_cfg;
      pv = rsp_valid_o;
      if (rsp_valid_o && stall > 0) begin
        rsp_ready_i = 1'b0;
        stall--;
      end else begin
        rsp_ready_i = rand_mode ? ($urandom_range(0, 1) == 1) : 1'b1;
      end
    end
  end

  // Monitor: stability under stalls and scoreboard comparison on each result handshake.
  initial begin : monitor
    bit mh;
    bit rh;
    logic [33:0] ma;
    logic [34:0] rs;
    exp_t e;
    mh = 1'b0; rh = 1'b0; ma = '0; rs = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        mh = 1'b0;
        rh = 1'b0;
      end else begin
        if (mh) begin
          chk("mem_req_hold_valid", 128'(mem_req_valid_o), 128'(1));
          chk("mem_req_hold_addr", 128'(mem_req_addr_o), 128'(ma));
        end
        mh = mem_req_valid_o && !mem_req_ready_i;
        ma = mem_req_addr_o;
        if (rh) begin
          chk("rsp_hold", 128'({rsp_valid_o, rsp_pte_o, rsp_level_o, rsp_page_fault_o, rsp_access_err_o}),
              128'({1'b1, rs}));
          chk("req_ready_busy", 128'(req_ready_o), 128'(0));
        end
        rh = rsp_valid_o && !rsp_ready_i;
        rs = {rsp_pte_o, rsp_level_o, rsp_page_fault_o, rsp_access_err_o};
        if (rsp_valid_o && rsp_ready_i) begin
          if (exp_q.size() == 0) begin
            tests++; fails++;
            $display("FAIL rsp_extra: got result pte 0x%0h, required none", rsp_pte_o);
          end else begin
            e = exp_q.pop_front();
            chk("rsp_pte", 128'(rsp_pte_o), 128'(e.pte));
            chk("rsp_level", 128'(rsp_level_o), 128'(e.level));
            chk("rsp_page_fault", 128'(rsp_page_fault_o), 128'(e.pf));
            chk("rsp_access_err", 128'(rsp_access_err_o), 128'(e.ae));
          end
          rsp_done++;
        end
      end
    end
  end

  task automatic issue(input logic [21:0] satp, input logic [19:0] vpn, output bit ok);
    int lim;
    ok = 1'b0;
    @(posedge clk); #1;
    req_valid_i = 1'b1;
    satp_ppn_i  = satp;
    req_vpn_i   = vpn;
    lim = 0;
    while (1) begin
      @(negedge clk);
      if (req_ready_o) break;
      if (++lim > 100) begin timeout("req_accept"); req_valid_i = 1'b0; return; end
    end
    @(posedge clk); #1;
    req_valid_i = 1'b0;
    satp_ppn_i  = 22'($urandom);
    req_vpn_i   = 20'($urandom);
    ok = 1'b1;
  endtask

  // One walk: push expectations, issue, optionally time the result, wait for completion.
  task automatic walk(input logic [21:0] satp, input logic [19:0] vpn, input int exp_lat);
    exp_t e;
    logic [33:0] a1, a0;
    int n, d0, lat, lim;
    bit ok;
    model(satp, vpn, e, a1, a0, n);
    exp_q.push_back(e);
    addr_q.push_back(a1);
    if (n == 2) addr_q.push_back(a0);
    d0 = rsp_done;
    issue(satp, vpn, ok);
    if (!ok) return;
    if (exp_lat > 0) begin
      lat = 0;
      while (1) begin
        @(negedge clk);
        lat++;
        if (rsp_valid_o) break;
        if (lat > 200) break;
      end
      chk("latency", 128'(lat), 128'(exp_lat));
    end
    lim = 0;
    while (rsp_done == d0) begin
      @(negedge clk);
      if (++lim > 500) begin timeout("rsp_done"); return; end
    end
    chk("mem_req_count", 128'(addr_q.size()), 128'(0));
  endtask

  initial begin : main
    logic [21:0] satp;
    logic [19:0] vpn;
    logic [33:0] a1, a0;
    logic [31:0] p;
    int m0, lim;
    bit ok;

    #2 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_outputs", 128'(outs()), 128'({1'b1, 1'b0, 1'b0, 34'd0, 32'd0, 3'd0}));
    rst_n = 1'b1;

    // 4 KiB walk, superpage, malformed and faulting walks on zero-wait memory.
    pmem[34'h1004] = 32'h0000_0801;
    pmem[34'h2004] = 32'h0000_0C0F;
    walk(22'h1, 20'h00401, 5);
    pmem[34'h1004] = 32'h0010_00CF;
    walk(22'h1, 20'h00401, 3);
    pmem[34'h1004] = 32'h0000_040F;
    walk(22'h1, 20'h00401, 3);
    pmem[34'h1004] = 32'h0000_0000;
    walk(22'h1, 20'h00401, 3);
    pmem[34'h1004] = 32'h0000_0005;
    walk(22'h1, 20'h00401, 3);
    pmem[34'h1004] = 32'h0000_0801;
    pmem[34'h2004] = 32'h0000_0801;
    walk(22'h1, 20'h00401, 5);
    pmem[34'h2004] = 32'h0000_0C0F;
    perr[34'h2004] = 1'b1;
    walk(22'h1, 20'h00401, 5);
    perr[34'h2004] = 1'b0;

    // Backpressure on both sides.
    mem_stall_cfg = 3;
    rsp_stall_cfg = 4;
    walk(22'h1, 20'h00401, 0);
    mem_stall_cfg = 0;
    rsp_stall_cfg = 0;

    // Spurious memory response while idle.
    spur_cnt++;
    repeat (4) begin
      @(negedge clk);
      chk("spurious_idle", 128'({rsp_valid_o, req_ready_o, mem_req_valid_o}), 128'(3'b010));
    end

    // Reset while waiting for the L1 PTE, then a stale response.
    hold_rsp = 1'b1;
    addr_q.push_back(34'h1004);
    m0 = mem_acc;
    issue(22'h1, 20'h00401, ok);
    lim = 0;
    while (ok && mem_acc == m0) begin
      @(negedge clk);
      if (++lim > 50) begin timeout("l1_accept"); break; end
    end
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    chk("reset_async", 128'(outs()), 128'({1'b1, 1'b0, 1'b0, 34'd0, 32'd0, 3'd0}));
    @(posedge clk); #3;
    rst_n = 1'b1;
    hold_rsp = 1'b0;
    repeat (6) begin
      @(negedge clk);
      chk("stale_rsp_dropped", 128'({rsp_valid_o, req_ready_o, mem_req_valid_o}), 128'(3'b010));
    end

    // Randomized walks with random stalls on both interfaces.
    rand_mode = 1'b1;
    for (int i = 0; i < 80; i++) begin
      satp = 22'($urandom);
      vpn  = 20'($urandom);
      a1 = 34'(satp) * 34'd4096 + 34'(vpn[19:10]) * 34'd4;
      pmem[a1] = gen_pte();
      perr[a1] = ($urandom_range(0, 9) == 0);
      p  = pmem[a1];
      a0 = 34'(p[31:10]) * 34'd4096 + 34'(vpn[9:0]) * 34'd4;
      pmem[a0] = gen_pte();
      perr[a0] = ($urandom_range(0, 9) == 0);
      walk(satp, vpn, 0);
    end
    rand_mode = 1'b0;
    repeat (5) @(posedge clk);
    chk("scoreboard_empty", 128'(exp_q.size()), 128'(0));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
